// File: rtl/pe_pkg.sv
// Shared PE definitions: MAC stream FSM states and default datapath widths.
package pe_pkg;

  localparam int unsigned PE_DATA_WIDTH = 16;
  localparam int unsigned PE_ACC_WIDTH  = 40;
  localparam int unsigned PE_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_e;

endpackage

// File: rtl/pe_mac_stream_if.sv
// FIFO-pop and result handshake bundle between a PE MAC stream and its FIFOs/writeback.
interface pe_mac_stream_if
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = PE_ACC_WIDTH
);
  logic                  act_empty;
  logic                  act_rd_en;
  logic [DATA_WIDTH-1:0] act_dout;
  logic                  wgt_empty;
  logic                  wgt_rd_en;
  logic [DATA_WIDTH-1:0] wgt_dout;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;

  modport master (
    input  act_empty, act_dout, wgt_empty, wgt_dout, res_ready,
    output act_rd_en, wgt_rd_en, res_valid, res_data
  );

  modport slave (
    output act_empty, act_dout, wgt_empty, wgt_dout, res_ready,
    input  act_rd_en, wgt_rd_en, res_valid, res_data
  );
endinterface

// File: rtl/pe_mul.sv
// Combinational signed DATA_WIDTH x DATA_WIDTH multiplier, full-width product.
module pe_mul
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic signed [2*DATA_WIDTH-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/pe_mac_stream.sv
// Streaming dot-product MAC: pops activation/weight pairs, accumulates, returns result.
// Build option PE_MAC_RELU_EN clamps negative results to zero.
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = PE_ACC_WIDTH,
  parameter int unsigned LEN_WIDTH  = PE_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  output logic                 busy,
  pe_mac_stream_if.master      bus
);
  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  pe_state_e                    state, state_nxt;
  logic [LEN_WIDTH-1:0]         len_q, issued_q;
  logic                         rd_vld_q;
  logic                         pop;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_sum, acc_fin, res_nxt;

  pe_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .a (bus.act_dout),
    .b (bus.wgt_dout),
    .p (prod)
  );

  assign acc_sum = acc_q + ACC_WIDTH'(prod);
  assign acc_fin = rd_vld_q ? acc_sum : acc_q;

  // Result value committed on entry to DONE
  always_comb begin
    res_nxt = acc_fin;
`ifdef PE_MAC_RELU_EN
    if (acc_fin[ACC_WIDTH-1]) res_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; pops are issued in pairs only while both FIFOs hold data
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (vec_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        pop = !bus.act_empty && !bus.wgt_empty && (issued_q < len_q);
        if (pop && (issued_q == len_q - LEN_WIDTH'(1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE: begin
        if (bus.res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.act_rd_en = pop;
  assign bus.wgt_rd_en = pop;

  // Datapath: issue counter, read-valid tracking, accumulator, result and status flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= '0;
      issued_q      <= '0;
      rd_vld_q      <= 1'b0;
      acc_q         <= '0;
      busy          <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      rd_vld_q      <= pop;
      busy          <= (state_nxt != ST_IDLE);
      bus.res_valid <= (state_nxt == ST_DONE);
      if (state == ST_IDLE && start) begin
        len_q    <= vec_len;
        issued_q <= '0;
        acc_q    <= '0;
        if (vec_len == '0) bus.res_data <= '0;
      end else begin
        if (pop)      issued_q <= issued_q + LEN_WIDTH'(1);
        if (rd_vld_q) acc_q    <= acc_sum;
        if (state == ST_DRAIN) bus.res_data <= res_nxt;
      end
    end
  end
endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench for pe_mac_stream: directed table, hand sequences, random vectors vs. a dot-product model.
module tb_pe_mac_stream;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 40;
  localparam int unsigned LW = 8;

  typedef struct {
    int     len;
    int     av[16];
    int     wv[16];
    int     stall_at;
    int     stall_len;
    int     hold;
    longint exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic          busy;
  logic          act_stall = 1'b0;
  logic          fifo_flush = 1'b0;
  logic          res_ready = 1'b1;

  int act_mem[512];
  int wgt_mem[512];
  int act_wr = 0, wgt_wr = 0, act_rd = 0, wgt_rd = 0;
  int act_pops = 0, wgt_pops = 0;
  int cyc = 0;
  int viol = 0;
  int nvec = 0, nerr = 0;

  pe_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  pe_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .vec_len (vec_len),
    .busy    (busy),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.act_empty = act_stall || (act_rd >= act_wr);
  assign bus.wgt_empty = (wgt_rd >= wgt_wr);
  assign bus.res_ready = res_ready;

  // FIFO models with one-cycle registered read data
  always @(posedge clk) begin
    if (fifo_flush) begin
      act_rd <= act_wr;
      wgt_rd <= wgt_wr;
    end else begin
      if (bus.act_rd_en) begin
        act_pops <= act_pops + 1;
        if (act_rd < act_wr) begin
          bus.act_dout <= DW'(act_mem[act_rd]);
          act_rd       <= act_rd + 1;
        end
      end
      if (bus.wgt_rd_en) begin
        wgt_pops <= wgt_pops + 1;
        if (wgt_rd < wgt_wr) begin
          bus.wgt_dout <= DW'(wgt_mem[wgt_rd]);
          wgt_rd       <= wgt_rd + 1;
        end
      end
    end
  end

  // Protocol watch: paired pops, never from an empty FIFO, never while idle or holding a result
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.act_rd_en !== bus.wgt_rd_en) viol <= viol + 1;
      else if (bus.act_rd_en && (bus.act_empty || bus.wgt_empty || !busy || bus.res_valid))
        viol <= viol + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] model(input int len, input int av[16], input int wv[16]);
    longint s = 0;
    for (int i = 0; i < len; i++) s += longint'(av[i]) * longint'(wv[i]);
`ifdef PE_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return AW'(s);
  endfunction

  // Called at a negedge; runs one dot product through to acceptance
  task automatic run_vec(input string name, input int len, input int av[16], input int wv[16],
                         input int stall_at, input int stall_len, input int hold,
                         input logic [AW-1:0] exp, input bit chk_lat, input bit mid_start);
    int s, k, sc, abase, wbase;
    bit stalled;
    abase = act_pops;
    wbase = wgt_pops;
    for (int i = 0; i < len; i++) begin
      act_mem[act_wr] = av[i]; act_wr++;
      wgt_mem[wgt_wr] = wv[i]; wgt_wr++;
    end
    res_ready = (hold == 0);
    start = 1'b1; vec_len = LW'(len); s = cyc;
    @(negedge clk);
    start = 1'b0; vec_len = LW'($urandom);
    k = 0; sc = 0; stalled = 1'b0;
    while (bus.res_valid !== 1'b1 && k < 300) begin
      if (mid_start && k == 0) begin start = 1'b1; vec_len = LW'(5); end
      else start = 1'b0;
      if (stall_len > 0 && !stalled && (act_pops - abase) >= stall_at) begin
        act_stall = 1'b1; sc = stall_len; stalled = 1'b1;
      end else if (act_stall) begin
        sc--;
        if (sc == 0) act_stall = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; act_stall = 1'b0;
    if (k >= 300) begin
      check({name, "_timeout"}, 64'd1, 64'd0);
      res_ready = 1'b1;
      return;
    end
    check({name, "_data"}, 64'(bus.res_data), 64'(exp));
    if (chk_lat) check({name, "_lat"}, 64'(cyc - s), 64'((len == 0) ? 1 : len + 2));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(bus.res_valid), 64'd1);
      check({name, "_hold_data"}, 64'(bus.res_data), 64'(exp));
      check({name, "_hold_busy"}, 64'(busy), 64'd1);
      check({name, "_hold_pops"}, 64'(act_pops - abase), 64'(len));
    end
    res_ready = 1'b1;
    @(negedge clk);
    check({name, "_accept_valid"}, 64'(bus.res_valid), 64'd0);
    check({name, "_accept_busy"}, 64'(busy), 64'd0);
    check({name, "_act_pops"}, 64'(act_pops - abase), 64'(len));
    check({name, "_wgt_pops"}, 64'(wgt_pops - wbase), 64'(len));
  endtask

  vec_t tbl[5];

  initial begin
    int av[16], wv[16];
    int n, sa, sl, hd, abase;
    logic [15:0] r;

    tbl[0] = '{len: 4, av: '{0:1, 1:2, 2:3, 3:4, default:0}, wv: '{0:5, 1:6, 2:7, 3:8, default:0},
               stall_at: 0, stall_len: 0, hold: 0, exp: 70};
    tbl[1] = '{len: 3, av: '{0:-3, 1:4, 2:-5, default:0}, wv: '{0:2, 1:-2, 2:-1, default:0},
               stall_at: 0, stall_len: 0, hold: 0,
`ifdef PE_MAC_RELU_EN
               exp: 0};
`else
               exp: -9};
`endif
    tbl[2] = '{len: 4, av: '{0:1, 1:2, 2:3, 3:4, default:0}, wv: '{0:5, 1:6, 2:7, 3:8, default:0},
               stall_at: 2, stall_len: 3, hold: 0, exp: 70};
    tbl[3] = '{len: 0, av: '{default:0}, wv: '{default:0},
               stall_at: 0, stall_len: 0, hold: 0, exp: 0};
    tbl[4] = '{len: 4, av: '{0:1, 1:2, 2:3, 3:4, default:0}, wv: '{0:5, 1:6, 2:7, 3:8, default:0},
               stall_at: 0, stall_len: 0, hold: 5, exp: 70};

    #2;
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_data", 64'(bus.res_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'({bus.act_rd_en, bus.wgt_rd_en}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("tbl%0d", i), tbl[i].len, tbl[i].av, tbl[i].wv, tbl[i].stall_at,
              tbl[i].stall_len, tbl[i].hold, AW'(tbl[i].exp), tbl[i].stall_len == 0, 1'b0);

    // start pulsed while busy must be ignored
    av = '{0:10, 1:-20, 2:30, default:0};
    wv = '{0:3, 1:4, 2:-5, default:0};
    run_vec("midstart", 3, av, wv, 0, 0, 0, model(3, av, wv), 1'b1, 1'b1);

    // reset asserted mid-RUN after two pairs popped
    av = '{0:7, 1:8, 2:9, 3:10, default:0};
    wv = '{0:1, 1:1, 2:1, 3:1, default:0};
    for (int i = 0; i < 4; i++) begin
      act_mem[act_wr] = av[i]; act_wr++;
      wgt_mem[wgt_wr] = wv[i]; wgt_wr++;
    end
    abase = act_pops;
    start = 1'b1; vec_len = LW'(4);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((act_pops - abase) < 2 && n < 20) begin @(negedge clk); n++; end
    check("rstmid_reached", 64'(act_pops - abase), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_valid", 64'(bus.res_valid), 64'd0);
    check("rstmid_data", 64'(bus.res_data), 64'd0);
    check("rstmid_rd_en", 64'({bus.act_rd_en, bus.wgt_rd_en}), 64'd0);
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    av = '{0:1, 1:1, default:0};
    wv = '{0:1, 1:1, default:0};
    run_vec("after_rst", 2, av, wv, 0, 0, 0, AW'(2), 1'b1, 1'b0);

    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(16, 1);
      av = '{default:0};
      wv = '{default:0};
      for (int i = 0; i < n; i++) begin
        r = 16'($urandom); av[i] = int'($signed(r));
        r = 16'($urandom); wv[i] = int'($signed(r));
      end
      sl = ($urandom_range(2, 0) == 0) ? $urandom_range(4, 1) : 0;
      sa = $urandom_range(n - 1, 0);
      hd = $urandom_range(3, 0);
      run_vec($sformatf("rnd%0d", v), n, av, wv, sa, sl, hd, model(n, av, wv), sl == 0, 1'b0);
    end

    check("protocol_violations", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
